reg_bank_arbiter: RTL

// - Shares one config/status register bank between two requesters: m0 (SPI peripheral side) and m1 (on-chip sequencer).
// - Serialises accesses with a req/ack handshake and round-robin arbitration.
// - Owns the config register storage. Exports it flat; samples flat status inputs.
// - Only one access is in flight at a time.

---
 rtl/reg_bank_arbiter.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: shares one config/status register bank between two
// requesters (m0, m1) using a req/ack handshake and round-robin arbitration.
// Optional feature macro: REG_ARB_LOCK_EN adds m0_lock/m1_lock grant holding.
//
// Handshake: a requester raises mX_req (level) with wr/addr/wdata and keeps
// it high until it samples mX_ack=1 on a rising edge; ack is a one-cycle
// pulse and err/rdata are valid while ack is high. The request fields are
// latched at grant, so later changes are ignored. While a requester's own ack
// is high its req is not considered, so a req still high after the ack edge
// becomes a new access at the following IDLE.
module reg_bank_arbiter #(
  parameter int NUM_CFG    = 8,
  parameter int NUM_STATUS = 8,
  parameter int REG_WIDTH  = 8,
  localparam int ADDR_WIDTH = $clog2(NUM_CFG + NUM_STATUS)
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic                            ena,
  input  logic                            m0_req,
  input  logic                            m0_wr,
  input  logic [ADDR_WIDTH-1:0]           m0_addr,
  input  logic [REG_WIDTH-1:0]            m0_wdata,
  output logic                            m0_ack,
  output logic                            m0_err,
  output logic [REG_WIDTH-1:0]            m0_rdata,
  input  logic                            m1_req,
  input  logic                            m1_wr,
  input  logic [ADDR_WIDTH-1:0]           m1_addr,
  input  logic [REG_WIDTH-1:0]            m1_wdata,
  output logic                            m1_ack,
  output logic                            m1_err,
  output logic [REG_WIDTH-1:0]            m1_rdata,
`ifdef REG_ARB_LOCK_EN
  input  logic                            m0_lock,
  input  logic                            m1_lock,
`endif
  output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
  input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
  output logic [1:0]                      dbg_state
);

  localparam int IDX_W = $clog2(NUM_CFG);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  gnt_q, gnt_d;     // id of the granted requester
  logic                  last_q, last_d;   // id granted most recently
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REG_WIDTH-1:0]  wdata_q, wdata_d;
  logic                  flag_q, flag_d;   // error flagged in ACCESS
  logic [REG_WIDTH-1:0]  cfg_q [NUM_CFG];
  logic [REG_WIDTH-1:0]  cfg_d [NUM_CFG];
  logic                  m0_ack_q, m0_ack_d, m0_err_q, m0_err_d;
  logic                  m1_ack_q, m1_ack_d, m1_err_q, m1_err_d;
  logic [REG_WIDTH-1:0]  m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
`ifdef REG_ARB_LOCK_EN
  logic                  hold_q, hold_d;   // grant held for last_q
`endif

  logic [REG_WIDTH-1:0]  status_arr [NUM_STATUS];
  logic                  r0, r1, win;
  logic [IDX_W-1:0]      idx;
  logic [REG_WIDTH-1:0]  rd_val;

  // Unpack the flat status bus and pack the config storage onto its bus.
  always_comb begin
    config_regs = '0;
    for (int i = 0; i < NUM_STATUS; i++) begin
      status_arr[i] = status_regs[i*REG_WIDTH +: REG_WIDTH];
    end
    for (int i = 0; i < NUM_CFG; i++) begin
      config_regs[i*REG_WIDTH +: REG_WIDTH] = cfg_q[i];
    end
  end

  // Next-state, arbitration and datapath; everything holds while ena=0.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    flag_d     = flag_q;
    cfg_d      = cfg_q;
    m0_ack_d   = m0_ack_q;
    m0_err_d   = m0_err_q;
    m0_rdata_d = m0_rdata_q;
    m1_ack_d   = m1_ack_q;
    m1_err_d   = m1_err_q;
    m1_rdata_d = m1_rdata_q;
`ifdef REG_ARB_LOCK_EN
    hold_d     = hold_q;
`endif
    r0     = 1'b0;
    r1     = 1'b0;
    win    = 1'b0;
    idx    = addr_q[IDX_W-1:0];
    rd_val = '0;
    if (ena) begin
      m0_ack_d = 1'b0;
      m0_err_d = 1'b0;
      m1_ack_d = 1'b0;
      m1_err_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          r0 = m0_req & ~m0_ack_q;
          r1 = m1_req & ~m1_ack_q;
`ifdef REG_ARB_LOCK_EN
          if (hold_q) begin
            if (last_q) r0 = 1'b0;
            else        r1 = 1'b0;
          end
`endif
          if (r0 | r1) begin
            win     = (r0 & r1) ? ~last_q : r1;
            gnt_d   = win;
            wr_d    = win ? m1_wr    : m0_wr;
            addr_d  = win ? m1_addr  : m0_addr;
            wdata_d = win ? m1_wdata : m0_wdata;
            state_d = ACCESS;
          end
        end
        ACCESS: begin
          flag_d = 1'b0;
          if (wr_q) begin
            if (addr_q[ADDR_WIDTH-1]) flag_d = 1'b1;
            else                      cfg_d[idx] = wdata_q;
          end else begin
            rd_val = addr_q[ADDR_WIDTH-1] ? status_arr[idx] : cfg_q[idx];
            if (gnt_q) m1_rdata_d = rd_val;
            else       m0_rdata_d = rd_val;
          end
          state_d = RESP;
        end
        RESP: begin
          if (gnt_q) begin
            m1_ack_d = 1'b1;
            m1_err_d = flag_q;
          end else begin
            m0_ack_d = 1'b1;
            m0_err_d = flag_q;
          end
          last_d  = gnt_q;
`ifdef REG_ARB_LOCK_EN
          hold_d  = gnt_q ? m1_lock : m0_lock;
`endif
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and storage registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      flag_q     <= 1'b0;
      for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= '0;
      m0_ack_q   <= 1'b0;
      m0_err_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_ack_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      m1_rdata_q <= '0;
`ifdef REG_ARB_LOCK_EN
      hold_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      flag_q     <= flag_d;
      cfg_q      <= cfg_d;
      m0_ack_q   <= m0_ack_d;
      m0_err_q   <= m0_err_d;
      m0_rdata_q <= m0_rdata_d;
      m1_ack_q   <= m1_ack_d;
      m1_err_q   <= m1_err_d;
      m1_rdata_q <= m1_rdata_d;
`ifdef REG_ARB_LOCK_EN
      hold_q     <= hold_d;
`endif
    end
  end

  assign m0_ack    = m0_ack_q;
  assign m0_err    = m0_err_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_ack    = m1_ack_q;
  assign m1_err    = m1_err_q;
  assign m1_rdata  = m1_rdata_q;
  assign dbg_state = state_q;

endmodule
